button_conditioner: RTL

- Upstream stage of the main game FSM.
- Converts the four raw, asynchronous board push-buttons into the single-cycle press pulses that the FSM consumes as btnR/btnU/btnD/btnL.
- Per button: 2-FF synchroniser, counter-based debouncer, and rising-edge pulse generator; also exports debounced levels.
- Every physical press yields exactly one FSM step, so menu arrows and screen transitions advance once per press.

---
 rtl/button_conditioner.sv | 109 ++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Four-channel push-button conditioner: 2-FF sync, counter debounce, registered rising-edge press pulse.
// Pulse/level rise DEBOUNCE_CYCLES+1 edges after raw is first sampled; BTN_AUTOREPEAT_EN adds held-key repeat pulses.
module button_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 650000,
    parameter int         CNT_W           = 20,
    parameter int         REPEAT_DELAY    = 32500000,
    parameter int         REPEAT_PERIOD   = 13000000,
    parameter logic [3:0] REPEAT_MASK     = 4'b1001
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       btnR_raw,
    input  logic       btnU_raw,
    input  logic       btnD_raw,
    input  logic       btnL_raw,
    output logic       btnR,
    output logic       btnU,
    output logic       btnD,
    output logic       btnL,
    output logic [3:0] btn_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw_w;
    logic [3:0]       s1_q;
    logic [3:0]       s2_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [3:0]       press_d;
    logic [3:0]       pulse_q;
    logic [3:0]       pulse_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    assign raw_w = {btnL_raw, btnD_raw, btnU_raw, btnR_raw};

    // The level flips only after s2 has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int c = 0; c < 4; c++) begin
            cnt_d[c] = '0;
            if (s2_q[c] != stable_q[c]) begin
                if (cnt_q[c] == CNT_LAST) begin
                    stable_d[c] = s2_q[c];
                    press_d[c]  = s2_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int               RPT_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_q [4];
    logic [RPT_W-1:0] rpt_d [4];
    logic [3:0]       rpt_fire;

    // After the first repeat the timer reloads so it re-reaches RPT_FIRE every REPEAT_PERIOD cycles.
    always_comb begin
        rpt_fire = '0;
        for (int c = 0; c < 4; c++) begin
            rpt_d[c] = '0;
            if (REPEAT_MASK[c] && stable_d[c] && !press_d[c]) begin
                rpt_d[c]    = (rpt_q[c] == RPT_FIRE) ? RPT_RELOAD + RPT_W'(1)
                                                      : rpt_q[c] + RPT_W'(1);
                rpt_fire[c] = (rpt_d[c] == RPT_FIRE);
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) rpt_q[c] <= '0;
        end else begin
            for (int c = 0; c < 4; c++) rpt_q[c] <= rpt_d[c];
        end
    end

    assign pulse_d = press_d | rpt_fire;
`else
    assign pulse_d = press_d;
`endif

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            for (int c = 0; c < 4; c++) cnt_q[c] <= '0;
        end else begin
            s1_q     <= raw_w;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int c = 0; c < 4; c++) cnt_q[c] <= cnt_d[c];
        end
    end

    assign {btnL, btnD, btnU, btnR} = pulse_q;
    assign btn_level                = stable_q;

endmodule
